mem_write_port: RTL and testbench

MEM_WRITE_PORT -- requirements
Module: mem_write_port

---
 rtl/mem_pkg.sv | 20 ++
 rtl/store_align.sv | 44 ++++
 rtl/mem_write_port.sv | 115 +++++++++++
 tb/tb_mem_write_port.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the store write port.
//   F3_SB/F3_SH/F3_SW : store-width encodings of funct3
//   state_t           : write-port FSM states
//   be_t              : 4-bit byte-enable vector, bit i = byte lane i
package mem_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  typedef logic [3:0] be_t;

endpackage

// File: rtl/store_align.sv
// store_align: combinational lane replication, byte-enable generation and
// alignment/legality check for a store.
//   addr_lo : low two bits of the store byte address
//   data    : store data (rs2)
//   funct3  : store width
//   wdata   : data replicated across the lanes the width covers
//   be      : byte enables for the addressed lanes
//   err     : illegal width or misaligned address
module store_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  input  logic [2:0]  funct3,
  output logic [31:0] wdata,
  output be_t         be,
  output logic        err
);

  always_comb begin
    wdata = '0;
    be    = '0;
    err   = 1'b1;
    case (funct3)
      F3_SB: begin
        wdata = {4{data[7:0]}};
        be    = be_t'(4'b0001 << addr_lo);
        err   = 1'b0;
      end
      F3_SH: begin
        wdata = {2{data[15:0]}};
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        err   = addr_lo[0];
      end
      F3_SW: begin
        wdata = data;
        be    = 4'b1111;
        err   = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_write_port.sv
// mem_write_port: issues one store to memory and waits for acknowledge,
// aborting after MAX_WAIT unacknowledged WRITE cycles.
//   clk, reset            : clock, synchronous active-high reset
//   st_req/st_addr/st_data/st_funct3 : store request (sampled in IDLE only)
//   mem_ack               : memory accepted the write
//   mem_addr/mem_wdata/mem_be/mem_we : registered memory write interface
//   st_busy/st_done/st_err: status back to the control FSM
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for st_req
// S_WRITE | mem_we high, waiting for mem_ack or timeout
// S_DONE  | one-cycle st_done pulse
// S_ERR   | one-cycle st_err pulse (rejected request or timeout)
module mem_write_port
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_funct3,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output be_t         mem_be,
  output logic        mem_we,
  output logic        st_busy,
  output logic        st_done,
  output logic        st_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  // Count value seen during the last allowed WRITE cycle.
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   al_wdata;
  be_t           al_be;
  logic          al_err;

  store_align u_align (
    .addr_lo (st_addr[1:0]),
    .data    (st_data),
    .funct3  (st_funct3),
    .wdata   (al_wdata),
    .be      (al_be),
    .err     (al_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      mem_we    <= 1'b0;
      st_busy   <= 1'b0;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
    end else begin
      st_done <= 1'b0;
      st_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (st_req) begin
            st_busy <= 1'b1;
            if (al_err) begin
              // Rejected requests leave the memory interface untouched.
              state  <= S_ERR;
              st_err <= 1'b1;
            end else begin
              state     <= S_WRITE;
              wait_cnt  <= '0;
              mem_addr  <= {st_addr[31:2], 2'b00};
              mem_wdata <= al_wdata;
              mem_be    <= al_be;
              mem_we    <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          // Ack is checked first so an ack in the last allowed cycle wins.
          if (mem_ack) begin
            state   <= S_DONE;
            mem_we  <= 1'b0;
            st_done <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == LAST_WAIT) begin
              state  <= S_ERR;
              mem_we <= 1'b0;
              st_err <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          state   <= S_IDLE;
          st_busy <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          mem_we  <= 1'b0;
          st_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_port.sv
// tb_mem_write_port: directed and random stores against a transaction-level
// reference model of the write port.
module tb_mem_write_port;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st_req = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [2:0]  st_funct3 = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic        st_busy;
  logic        st_done;
  logic        st_err;

  int n_checks = 0;
  int n_errors = 0;

  // Values the memory interface should be holding between stores.
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_be = '0;

  mem_write_port #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .st_req    (st_req),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_funct3 (st_funct3),
    .mem_ack   (mem_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_we    (mem_we),
    .st_busy   (st_busy),
    .st_done   (st_done),
    .st_err    (st_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Store semantics from plain arithmetic on the address and data.
  function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                                output bit legal, output logic [31:0] ea,
                                output logic [31:0] ew, output logic [3:0] eb);
    ea    = a - (a % 4);
    legal = 1'b1;
    ew    = '0;
    eb    = '0;
    case (f3)
      3'd0: begin
        ew = (d & 32'h0000_00FF) * 32'h0101_0101;
        eb = 4'(1 << (a % 4));
      end
      3'd1: begin
        legal = ((a % 2) == 0);
        ew    = (d & 32'h0000_FFFF) * 32'h0001_0001;
        eb    = ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
      end
      3'd2: begin
        legal = ((a % 4) == 0);
        ew    = d;
        eb    = 4'b1111;
      end
      default: legal = 1'b0;
    endcase
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(st_busy), 32'd0);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_done"}, 32'(st_done), 32'd0);
    check({tag, "_err"}, 32'(st_err), 32'd0);
    check({tag, "_addr"}, mem_addr, m_addr);
    check({tag, "_wdata"}, mem_wdata, m_wdata);
    check({tag, "_be"}, 32'(mem_be), 32'(m_be));
  endtask

  // ack_at: index of the WRITE cycle in which mem_ack is raised (beyond
  // MAX_WAIT means never). noise: wiggle st_req/st_addr during the store
  // and raise mem_ack in the DONE/ERR cycle.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                          input int ack_at, input bit noise);
    bit          legal;
    logic [31:0] ea, ew;
    logic [3:0]  eb;
    int          exp_we, exp_cyc, we_cnt, out_cyc;
    bit          exp_done, got_done, got_err;
    model(a, d, f3, legal, ea, ew, eb);
    if (!legal) begin
      exp_we = 0; exp_cyc = 1; exp_done = 1'b0;
    end else if (ack_at <= MAX_WAIT) begin
      exp_we = ack_at; exp_cyc = ack_at + 1; exp_done = 1'b1;
    end else begin
      exp_we = MAX_WAIT; exp_cyc = MAX_WAIT + 1; exp_done = 1'b0;
    end
    if (legal) begin
      m_addr = ea; m_wdata = ew; m_be = eb;
    end
    we_cnt = 0; out_cyc = 0; got_done = 1'b0; got_err = 1'b0;
    @(negedge clk);
    st_req = 1'b1; st_addr = a; st_data = d; st_funct3 = f3; mem_ack = 1'b0;
    for (int c = 1; c <= MAX_WAIT + 8; c++) begin
      @(posedge clk); #1;
      check("busy", 32'(st_busy), 32'd1);
      check("done_err_excl", 32'(st_done & st_err), 32'd0);
      if (mem_we) begin
        we_cnt++;
        if (we_cnt == 1) begin
          check("addr", mem_addr, ea);
          check("wdata", mem_wdata, ew);
          check("be", 32'(mem_be), 32'(eb));
        end
      end
      if (st_done || st_err) begin
        got_done = st_done; got_err = st_err; out_cyc = c;
        check("we_at_end", 32'(mem_we), 32'd0);
        st_req  = 1'b0;
        mem_ack = noise;
        break;
      end
      mem_ack = mem_we && (we_cnt == ack_at);
      st_req  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        st_addr   = $urandom;
        st_data   = $urandom;
        st_funct3 = 3'($urandom_range(0, 7));
      end
    end
    check("got_done", 32'(got_done), 32'(exp_done));
    check("got_err", 32'(got_err), 32'(!exp_done));
    check("we_cycles", 32'(we_cnt), 32'(exp_we));
    check("end_cycle", 32'(out_cyc), 32'(exp_cyc));
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check_idle("post");
  endtask

  task automatic reset_mid_write();
    @(negedge clk);
    st_req = 1'b1; st_addr = 32'h0000_0010; st_data = 32'hCAFE_0000;
    st_funct3 = 3'b010; mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_we_before", 32'(mem_we), 32'd1);
      // A second request during WRITE must not disturb the store.
      st_req = 1'b1; st_addr = 32'h0000_0F00; st_funct3 = 3'b000;
    end
    check("rst_second_req_addr", mem_addr, 32'h0000_0010);
    check("rst_second_req_wdata", mem_wdata, 32'hCAFE_0000);
    @(negedge clk);
    reset = 1'b1; mem_ack = 1'b1;
    @(posedge clk); #1;
    m_addr = '0; m_wdata = '0; m_be = '0;
    check_idle("rst_mid");
    @(negedge clk);
    reset = 1'b0; st_req = 1'b0; mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_idle("rst_after");
    end
  endtask

  initial begin
    reset = 1'b1;
    st_req = 1'b1; mem_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    reset = 1'b0; st_req = 1'b0; mem_ack = 1'b0;

    do_store(32'h0000_1003, 32'h1234_56AB, 3'b000, 3, 1'b0);
    do_store(32'h0000_2002, 32'h0000_BEEF, 3'b001, 1, 1'b0);
    do_store(32'h0000_0006, 32'h5555_AAAA, 3'b010, 1, 1'b0);
    do_store(32'h0000_0000, 32'h5555_AAAA, 3'b011, 1, 1'b0);
    do_store(32'h0000_0010, 32'h0BAD_F00D, 3'b010, 99, 1'b0);
    do_store(32'h0000_0010, 32'h0BAD_F00D, 3'b010, MAX_WAIT, 1'b0);
    do_store(32'h0000_0014, 32'h7777_8888, 3'b010, MAX_WAIT - 1, 1'b0);
    do_store(32'h0000_0021, 32'h0000_1234, 3'b001, 1, 1'b0);
    reset_mid_write();
    // Wait counter must start from zero again after the aborted store.
    do_store(32'h0000_0040, 32'h1111_2222, 3'b010, 99, 1'b1);

    for (int i = 0; i < 60; i++) begin
      logic [2:0] f3;
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      do_store($urandom, $urandom, f3, $urandom_range(1, MAX_WAIT + 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
